// File: rtl/snake_body_engine.sv
// Snake position engine: segment storage, direction latch, growth and a
// one-compare-per-cycle self/wall collision scan behind an indexed read port.
module snake_body_engine #(
    parameter int COORD_W   = 10,
    parameter int MAX_LEN   = 32,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int START_X   = 20,
    parameter int START_Y   = 15,
    parameter int START_LEN = 3
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         restart,
    input  logic                         step,
    input  logic                         grow,
    input  logic                         Up,
    input  logic                         Down,
    input  logic                         Left,
    input  logic                         Right,
    input  logic                         wallsOn,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
    output logic [COORD_W-1:0]           rd_x,
    output logic [COORD_W-1:0]           rd_y,
    output logic                         rd_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         busy,
    output logic                         step_done,
    output logic                         gameOver
);
    // state | meaning
    // IDLE  | waiting for an accepted step tick
    // MOVE  | compute next head; wall kill or shift the body
    // CHECK | compare seg[checkIdx] against the new head, one per cycle
    typedef enum logic [1:0] {IDLE, MOVE, CHECK} state_t;

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(GRID_H - 1);

    state_t state, nextState;

    logic [COORD_W-1:0] segX [MAX_LEN];
    logic [COORD_W-1:0] segY [MAX_LEN];
    logic [1:0]         dir;
    logic [1:0]         lastDir;
    logic               growReg;
    logic [LEN_W-1:0]   checkIdx;

    logic [2:0]         btnCount;
    logic [1:0]         dirReq;
    logic               dirLoad;
    logic [COORD_W-1:0] headX;
    logic [COORD_W-1:0] headY;
    logic               edgeHit;
    logic               segMatch;
    logic               lastCheck;
    logic               accept;
    logic               moveOk;
    logic               wallKill;
    logic               selfHit;
    logic               finish;

    function automatic logic [COORD_W-1:0] initX(input int i);
        return (i < START_LEN) ? COORD_W'(START_X - i) : '0;
    endfunction

    function automatic logic [COORD_W-1:0] initY(input int i);
        return (i < START_LEN) ? COORD_W'(START_Y) : '0;
    endfunction

    // A button is accepted only alone and never as a reversal of the last move.
    always_comb begin
        btnCount = {2'b0, Up} + {2'b0, Down} + {2'b0, Left} + {2'b0, Right};
        dirReq   = DIR_RIGHT;
        if (Up)        dirReq = DIR_UP;
        else if (Down) dirReq = DIR_DOWN;
        else if (Left) dirReq = DIR_LEFT;
        dirLoad  = (btnCount == 3'd1) && (dirReq != (lastDir ^ 2'b01));
    end

    always_comb begin
        headX   = segX[0];
        headY   = segY[0];
        edgeHit = 1'b0;
        case (dir)
            DIR_UP: begin
                if (segY[0] == '0) begin
                    edgeHit = 1'b1;
                    headY   = LAST_Y;
                end else headY = segY[0] - ONE;
            end
            DIR_DOWN: begin
                if (segY[0] == LAST_Y) begin
                    edgeHit = 1'b1;
                    headY   = '0;
                end else headY = segY[0] + ONE;
            end
            DIR_LEFT: begin
                if (segX[0] == '0) begin
                    edgeHit = 1'b1;
                    headX   = LAST_X;
                end else headX = segX[0] - ONE;
            end
            default: begin
                if (segX[0] == LAST_X) begin
                    edgeHit = 1'b1;
                    headX   = '0;
                end else headX = segX[0] + ONE;
            end
        endcase
    end

    always_comb begin
        segMatch  = (segX[checkIdx[IDX_W-1:0]] == segX[0]) &&
                    (segY[checkIdx[IDX_W-1:0]] == segY[0]);
        lastCheck = (checkIdx == (length - LEN_W'(1)));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)      state <= IDLE;
        else if (restart) state <= IDLE;
        else              state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (step && !gameOver) nextState = MOVE;
            MOVE:    nextState = (edgeHit && wallsOn) ? IDLE : CHECK;
            CHECK:   if (segMatch || lastCheck) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && step && !gameOver;
        wallKill = (state == MOVE) && edgeHit && wallsOn;
        moveOk   = (state == MOVE) && !(edgeHit && wallsOn);
        selfHit  = (state == CHECK) && segMatch;
        finish   = wallKill || ((state == CHECK) && (segMatch || lastCheck));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= initX(i);
                segY[i] <= initY(i);
            end
            dir       <= DIR_RIGHT;
            lastDir   <= DIR_RIGHT;
            length    <= LEN_W'(START_LEN);
            gameOver  <= 1'b0;
            step_done <= 1'b0;
            growReg   <= 1'b0;
            checkIdx  <= '0;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= initX(i);
                segY[i] <= initY(i);
            end
            dir       <= DIR_RIGHT;
            lastDir   <= DIR_RIGHT;
            length    <= LEN_W'(START_LEN);
            gameOver  <= 1'b0;
            step_done <= 1'b0;
            growReg   <= 1'b0;
            checkIdx  <= '0;
        end else begin
            step_done <= finish;
            if (dirLoad) dir <= dirReq;
            if (accept) growReg <= grow;
            if (moveOk) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    segX[i] <= segX[i-1];
                    segY[i] <= segY[i-1];
                end
                segX[0] <= headX;
                segY[0] <= headY;
                if (growReg && (length < LEN_W'(MAX_LEN))) length <= length + LEN_W'(1);
                lastDir  <= dir;
                checkIdx <= LEN_W'(1);
            end else if (state == CHECK) begin
                checkIdx <= checkIdx + LEN_W'(1);
            end
            if (wallKill || selfHit) gameOver <= 1'b1;
        end
    end

    always_comb begin
        rd_x     = segX[rd_idx];
        rd_y     = segY[rd_idx];
        rd_valid = (LEN_W'(rd_idx) < length);
    end
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed and randomized checks of snake_body_engine against a list-based
// reference model of the snake (segment array, direction, length, game-over).
`timescale 1ns/1ps
module tb_snake_body_engine;
    localparam int COORD_W = 10, MAX_LEN = 32, GRID_W = 40, GRID_H = 30;
    localparam int START_X = 20, START_Y = 15, START_LEN = 3;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    logic clock = 1'b0, resetn = 1'b0, restart = 1'b0, step = 1'b0, grow = 1'b0;
    logic Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0, wallsOn = 1'b0;
    logic [$clog2(MAX_LEN)-1:0]   rd_idx = '0;
    logic [COORD_W-1:0]           rd_x, rd_y;
    logic                         rd_valid, busy, step_done, gameOver;
    logic [$clog2(MAX_LEN+1)-1:0] length;

    snake_body_engine #(
        .COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .START_X(START_X), .START_Y(START_Y), .START_LEN(START_LEN)
    ) dut (
        .clock(clock), .resetn(resetn), .restart(restart), .step(step), .grow(grow),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right), .wallsOn(wallsOn),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .length(length), .busy(busy), .step_done(step_done), .gameOver(gameOver)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: the snake as a list of cells, head first.
    int mx [MAX_LEN];
    int my [MAX_LEN];
    int mlen, mdir, mlast;
    bit mover;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < MAX_LEN; i++) begin
            mx[i] = (i < START_LEN) ? START_X - i : 0;
            my[i] = (i < START_LEN) ? START_Y : 0;
        end
        mlen  = START_LEN;
        mdir  = D_RIGHT;
        mlast = D_RIGHT;
        mover = 1'b0;
    endtask

    task automatic snapshot(input string tag);
        chk({tag, " gameOver"}, 32'(gameOver), 32'(mover));
        chk({tag, " length"}, 32'(length), 32'(mlen));
        chk({tag, " busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < MAX_LEN; i++) begin
            rd_idx = 5'(i);
            #1;
            chk($sformatf("%s x[%0d]", tag, i), 32'(rd_x), 32'(mx[i]));
            chk($sformatf("%s y[%0d]", tag, i), 32'(rd_y), 32'(my[i]));
            chk($sformatf("%s valid[%0d]", tag, i), 32'(rd_valid), 32'(i < mlen));
        end
        rd_idx = '0;
    endtask

    task automatic headIs(input string tag, input int x, input int y);
        rd_idx = '0;
        #1;
        chk({tag, " head x"}, 32'(rd_x), 32'(x));
        chk({tag, " head y"}, 32'(rd_y), 32'(y));
    endtask

    task automatic doReset();
        resetn = 1'b0;
        restart = 1'b0; step = 1'b0; grow = 1'b0;
        {Up, Down, Left, Right} = 4'b0;
        #12;
        modelReset();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic doRestart();
        restart = 1'b1;
        step = 1'b1;
        cyc();
        restart = 1'b0;
        step = 1'b0;
        modelReset();
        cyc();
        chk("restart step_done", 32'(step_done), 32'd0);
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        int n, req;
        {Up, Down, Left, Right} = {u, d, l, r};
        cyc();
        {Up, Down, Left, Right} = 4'b0;
        n = int'(u) + int'(d) + int'(l) + int'(r);
        req = u ? D_UP : d ? D_DOWN : l ? D_LEFT : D_RIGHT;
        if (n == 1) begin
            if (!((req == D_UP && mlast == D_DOWN) || (req == D_DOWN && mlast == D_UP) ||
                  (req == D_LEFT && mlast == D_RIGHT) || (req == D_RIGHT && mlast == D_LEFT)))
                mdir = req;
        end
        cyc();
    endtask

    task automatic doStep(input bit g, input bit poke);
        int nx, ny, lat, k;
        bit seen, hit;
        if (mover) begin
            grow = g; step = 1'b1;
            cyc();
            step = 1'b0; grow = 1'b0;
            seen = 1'b0;
            repeat (6) begin
                cyc();
                if (step_done) seen = 1'b1;
            end
            chk("step ignored while gameOver", 32'(seen), 32'd0);
            snapshot("frozen");
            return;
        end
        nx = mx[0] + ((mdir == D_RIGHT) ? 1 : (mdir == D_LEFT) ? -1 : 0);
        ny = my[0] + ((mdir == D_DOWN) ? 1 : (mdir == D_UP) ? -1 : 0);
        hit = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
        if (hit && wallsOn) begin
            mover = 1'b1;
            lat = 1;
        end else begin
            nx = (nx + GRID_W) % GRID_W;
            ny = (ny + GRID_H) % GRID_H;
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                mx[i] = mx[i-1];
                my[i] = my[i-1];
            end
            mx[0] = nx;
            my[0] = ny;
            if (g && mlen < MAX_LEN) mlen++;
            mlast = mdir;
            lat = mlen;
            for (int i = 1; i < mlen; i++) begin
                if (!mover && mx[i] == nx && my[i] == ny) begin
                    mover = 1'b1;
                    lat = 1 + i;
                end
            end
        end
        grow = g; step = 1'b1;
        cyc();
        step = poke; grow = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 60) begin
            cyc();
            step = 1'b0;
            k++;
            if (k == 1 && lat > 1) chk("busy during step", 32'(busy), 32'd1);
            if (step_done) seen = 1'b1;
        end
        chk("step latency", seen ? 32'(k) : 32'd999, 32'(lat));
        chk("busy at step_done", 32'(busy), 32'd0);
        cyc();
        chk("step_done single pulse", 32'(step_done), 32'd0);
        snapshot("after step");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        doReset();
        snapshot("reset");
        chk("reset step_done", 32'(step_done), 32'd0);

        repeat (3) doStep(1'b0, 1'b0);
        headIs("three steps", 23, 15);
        rd_idx = 5'd2; #1;
        chk("three steps tail x", 32'(rd_x), 32'd21);

        press(0, 0, 1, 0);
        doStep(1'b0, 1'b1);
        headIs("reverse ignored", 24, 15);
        press(1, 0, 0, 1);
        doStep(1'b0, 1'b0);
        headIs("two buttons hold", 25, 15);
        press(1, 0, 0, 0);
        doStep(1'b0, 1'b0);
        headIs("turn up", 25, 14);
        press(0, 1, 0, 0);
        doStep(1'b0, 1'b0);
        headIs("down ignored", 25, 13);

        doRestart();
        snapshot("restart1");
        wallsOn = 1'b1;
        repeat (GRID_W - 1 - START_X) doStep(1'b0, 1'b0);
        headIs("at right wall", GRID_W - 1, START_Y);
        doStep(1'b0, 1'b0);
        chk("wall kill gameOver", 32'(gameOver), 32'd1);
        headIs("wall kill frozen", GRID_W - 1, START_Y);
        doStep(1'b1, 1'b0);
        press(1, 0, 0, 0);
        doRestart();
        snapshot("restart after wall");

        wallsOn = 1'b0;
        repeat (GRID_W - START_X) doStep(1'b0, 1'b0);
        headIs("wrap x", 0, START_Y);
        chk("wrap x alive", 32'(gameOver), 32'd0);
        press(1, 0, 0, 0);
        repeat (START_Y + 1) doStep(1'b0, 1'b0);
        headIs("wrap y", 0, GRID_H - 1);

        doRestart();
        repeat (5) doStep(1'b1, 1'b0);
        chk("grow five", 32'(length), 32'd8);
        repeat (30) doStep(1'b1, 1'b0);
        chk("grow saturates", 32'(length), 32'(MAX_LEN));

        doRestart();
        doStep(1'b1, 1'b0);
        press(1, 0, 0, 0); doStep(1'b0, 1'b0);
        press(0, 0, 1, 0); doStep(1'b0, 1'b0);
        press(0, 1, 0, 0); doStep(1'b0, 1'b0);
        chk("len4 U-turn safe", 32'(gameOver), 32'd0);

        doRestart();
        repeat (3) doStep(1'b1, 1'b0);
        press(1, 0, 0, 0); doStep(1'b0, 1'b0);
        press(0, 0, 1, 0); doStep(1'b0, 1'b0);
        press(0, 1, 0, 0); doStep(1'b0, 1'b0);
        chk("len6 U-turn collides", 32'(gameOver), 32'd1);
        doStep(1'b0, 1'b0);

        doRestart();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset step_done", 32'(step_done), 32'd0);
        modelReset();
        #4;
        resetn = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            repeat (6) begin
                cyc();
                if (step_done) seen = 1'b1;
            end
            chk("no step_done after async reset", 32'(seen), 32'd0);
        end
        snapshot("async reset");

        for (int it = 0; it < 200; it++) begin
            if (mover && $urandom_range(0, 1) == 0) doRestart();
            if (it % 25 == 0) wallsOn = 1'($urandom_range(0, 1));
            begin
                logic [3:0] b;
                b = 4'($urandom_range(0, 15));
                press(b[3], b[2], b[1], b[0]);
            end
            doStep($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
